// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit: PC, imem initiator, prefetch FIFO, redirect flush
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_word,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      mem_pc_q   [DEPTH];
  logic [31:0]      mem_pc_d   [DEPTH];
  logic [31:0]      mem_word_q [DEPTH];
  logic [31:0]      mem_word_d [DEPTH];

  logic pop;
  logic push;

  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != '0);
  // Head is read from registered storage only, never from imem_word.
  assign inst_word  = mem_word_q[rd_ptr_q];
  assign inst_pc    = mem_pc_q[rd_ptr_q];

  assign pop  = inst_valid & inst_ready;
  assign push = fetch_en & ~redirect_valid & ((count_q < CNT_W'(DEPTH)) | pop);

  always_comb begin
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_pc_d   = mem_pc_q;
    mem_word_d = mem_word_q;
    if (redirect_valid) begin
      // A same-cycle pop is consumed by decode; the flush discards the rest.
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]   = pc_q;
        mem_word_d[wr_ptr_q] = imem_word;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        pc_d                 = pc_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_word_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_pc_q   <= mem_pc_d;
      mem_word_q <= mem_word_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] RPC   = 32'h0000_0010;
  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_word;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  assign imem_word = imem_addr ^ KEY;

  instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_word(imem_word),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_word(inst_word), .inst_pc(inst_pc)
  );

  typedef struct {
    logic        fe;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = RPC;
  endtask

  // Reference behaviour at one rising edge, from the inputs of that cycle.
  task automatic model_edge(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit pop;
    bit push;
    pop  = (m_q.size() != 0) && rdy;
    push = fe && !rv && ((m_q.size() < DEPTH) || pop);
    if (rv) begin
      m_q.delete();
      m_pc = rpc;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_addr"}, imem_addr, m_pc);
    chk({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk({tag, "_pc"}, inst_pc, m_q[0]);
      chk({tag, "_word"}, inst_word, m_q[0] ^ KEY);
    end
  endtask

  // Called at a negedge: apply inputs, take the edge, return at next negedge.
  task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(posedge clk);
    model_edge(fe, rv, rpc, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    fetch_en = 0; redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] hold_word;

    vecs[0]  = '{1, 0, 32'h0,         1, 0, 32'h0,         32'h10};
    vecs[1]  = '{1, 0, 32'h0,         1, 1, 32'h10,        32'h11};
    vecs[2]  = '{1, 0, 32'h0,         1, 1, 32'h11,        32'h12};
    vecs[3]  = '{1, 0, 32'h0,         0, 1, 32'h12,        32'h13};
    vecs[4]  = '{1, 0, 32'h0,         0, 1, 32'h12,        32'h14};
    vecs[5]  = '{1, 0, 32'h0,         0, 1, 32'h12,        32'h14};
    vecs[6]  = '{1, 0, 32'h0,         1, 1, 32'h12,        32'h14};
    vecs[7]  = '{1, 0, 32'h0,         1, 1, 32'h13,        32'h15};
    vecs[8]  = '{1, 1, 32'h40,        1, 1, 32'h14,        32'h16};
    vecs[9]  = '{1, 0, 32'h0,         1, 0, 32'h0,         32'h40};
    vecs[10] = '{1, 0, 32'h0,         1, 1, 32'h40,        32'h41};
    vecs[11] = '{1, 1, 32'hFFFF_FFFF, 1, 1, 32'h41,        32'h42};
    vecs[12] = '{1, 0, 32'h0,         1, 0, 32'h0,         32'hFFFF_FFFF};
    vecs[13] = '{1, 0, 32'h0,         1, 1, 32'hFFFF_FFFF, 32'h0};
    vecs[14] = '{0, 0, 32'h0,         1, 1, 32'h0,         32'h1};
    vecs[15] = '{0, 0, 32'h0,         1, 0, 32'h0,         32'h1};
    vecs[16] = '{0, 0, 32'h0,         1, 0, 32'h0,         32'h1};
    vecs[17] = '{1, 0, 32'h0,         1, 0, 32'h0,         32'h1};

    do_reset();
    chk("reset_inst_pc", inst_pc, 32'h0);
    chk("reset_inst_word", inst_word, 32'h0);

    for (int i = 0; i < 18; i++) begin
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), inst_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d_word", i), inst_word, vecs[i].exp_pc ^ KEY);
      end
      step(vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
    end

    // Back-to-back redirects: last target wins, bubble restarts.
    step(1, 1, 32'h100, 1);
    chk("b2b_valid0", {31'd0, inst_valid}, 32'd0);
    step(1, 1, 32'h200, 1);
    chk("b2b_valid1", {31'd0, inst_valid}, 32'd0);
    chk("b2b_addr", imem_addr, 32'h200);
    step(1, 0, 32'h0, 1);
    chk("b2b_pc", inst_pc, 32'h200);
    chk("b2b_valid2", {31'd0, inst_valid}, 32'd1);

    // Fill to full, then assert reset between edges.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    hold_pc = inst_pc;
    hold_word = inst_word;
    chk("bp_hold_pc", hold_pc, RPC);
    chk("bp_hold_word", hold_word, RPC ^ KEY);
    chk("bp_addr", imem_addr, RPC + 32'd2);
    #2 rst_n = 0;
    #1;
    chk("async_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_addr", imem_addr, RPC);
    chk("async_pc", inst_pc, 32'h0);
    chk("async_word", inst_word, 32'h0);
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // Randomised run against the queue model.
    for (int n = 0; n < 400; n++) begin
      logic fe, rv, rdy;
      logic [31:0] rpc;
      model_check("rand");
      fe  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      step(fe, rv, rpc, rdy);
    end
    model_check("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: the initiator side of the instruction memory interface. It owns the program counter and drives the word address into the combinational instruction ROM. It captures the returned word together with its PC into a small prefetch FIFO, and presents instructions to decode through a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and reload the PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of two, 2..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new fetches; when 0, no push and PC holds.
- imem_addr  out  32  word address to instruction memory; equals PC combinationally.
- imem_word  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  one-cycle request to change the fetch stream.
- redirect_pc  in  32  target word address, sampled when redirect_valid=1.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_word  out  32  instruction at the FIFO head.
- inst_pc  out  32  word address of inst_word.

## Operation
- PC is word-indexed. Sequential fetch adds 1; addition is 32-bit and wraps from 32'hFFFF_FFFF to 0.
- pop = inst_valid & inst_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop). On push, {PC, imem_word} is written at the tail and PC <= PC + 1.
- When the FIFO is full, push and pop in the same cycle are both performed and count is unchanged.
- Redirect has priority over everything else:
  - At the edge, count <= 0 and the pointers reset.
  - PC <= redirect_pc.
  - No push occurs.
  - A pop in the same cycle still counts as a completed transfer for decode; the popped entry is consumed, then the FIFO is flushed.
- fetch_en=0: PC, FIFO contents and pop behaviour are unchanged. Draining continues.
- inst_word and inst_pc come from the registered head entry, with no combinational path from imem_word. They are held stable while inst_valid=1 and inst_ready=0.
- count ranges 0..DEPTH. inst_valid = (count != 0).
- Reset, asynchronous and usable mid-stream:
  - PC = RESET_PC.
  - count = 0.
  - Pointers = 0.
  - All FIFO entries = 0.
  - inst_valid = 0, inst_word = 0, inst_pc = 0.
  - imem_addr = RESET_PC.
  - Any in-flight entries are discarded.

## Timing
- Latency from address to output: the word fetched in cycle n is visible on inst_word with inst_valid=1 in cycle n+1.
- Throughput: with inst_ready held high, fetch_en=1 and no redirect, one instruction per cycle indefinitely after a single fill cycle.
- First cycle after rst_n rises: imem_addr = RESET_PC, inst_valid = 0. The next cycle presents inst_pc = RESET_PC.
- Redirect at edge k:
  - From k, imem_addr = redirect_pc and inst_valid = 0.
  - At k+1, the target is pushed.
  - After k+1, inst_pc = redirect_pc with inst_valid = 1.
  - Redirect penalty is one bubble cycle.
- Back-to-back redirects: the last one wins, and each resets the bubble.
- Backpressure: when count = DEPTH and inst_ready = 0, PC holds and imem_addr holds.

## Test plan
- Reset then streaming: RESET_PC=0x10, inst_ready=1, ROM word = addr ^ 0xA5A5_0000 -> inst_valid rises one cycle after reset release. inst_pc reads 0x10, 0x11, 0x12… consecutively with matching words, and there are no gaps.
- Backpressure: DEPTH=2, hold inst_ready=0 for 5 cycles -> count saturates at 2, PC stops at head+2, and inst_word/inst_pc stay stable. On release, the sequence resumes with no loss or duplication.
- Redirect with pop: in the same cycle, inst_ready=1 and redirect_valid=1 with redirect_pc=0x40 -> the current head is consumed once, the next cycle has inst_valid=0, and the following cycle has inst_pc=0x40.
- Simultaneous push/pop when full: FIFO full, inst_ready=1 for one cycle -> count stays 2, and exactly one new entry enters while one leaves.
- Wrap-around and fetch_en:
  - Redirect to 0xFFFF_FFFF -> inst_pc sequence is 0xFFFF_FFFF then 0x0000_0000.
  - fetch_en=0 for 3 cycles -> the FIFO drains to empty and PC is unchanged.
- Asynchronous reset mid-stream: assert rst_n=0 between clock edges while count=2 -> inst_valid=0 and imem_addr=RESET_PC immediately, with no clock edge needed.
